// File: rtl/ppe_stream_engine_if.sv
// ppe_stream_engine_if: ingress/egress valid-ready packet channels of the
// partial-product stream engine.
//   in_valid/in_ready/in_data    : packets from the router ingress port
//   out_valid/out_ready/out_data : psum packets towards the router egress port
// master = router side, slave = engine side.
interface ppe_stream_engine_if #(
  parameter int PKT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [PKT_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [PKT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ppe_stream_engine.sv
// ppe_stream_engine: loads a filter-weight row and an ifmap spike row from
// NoC packets. On START it slides the filter across the spike row, one tap
// per clock, and emits one psum packet per output position.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   io (slave) : in_valid/in_ready/in_data ingress, out_valid/out_ready/out_data egress
//   busy       : high whenever the engine is not idle
// Ingress packet : [31:28] dest (ignored), [27:24] opcode, [23:0] payload
// Egress packet  : [31:28] dest_reg, [27:24] 4'h8, [23:16] pos, [15:0] psum
// Optional build macro PPE_ZERO_SKIP_EN: zero psums are not emitted. After the
// last position a trailer packet (opcode 4'h9, payload[7:0] = psum packets
// sent) marks the end of the row.
module ppe_stream_engine #(
  parameter int FILTER_W   = 5,
  parameter int NUM_INPUTS = 25,
  parameter int WEIGHT_W   = 8,
  parameter int PSUM_W     = 11,
  parameter int ADDR_W     = 4,
  parameter int OP_W       = 4,
  parameter int PKT_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  ppe_stream_engine_if.slave  io,
  output logic                busy
);
  localparam int NUM_OUT = NUM_INPUTS - FILTER_W + 1;
  localparam int PL_W    = PKT_W - ADDR_W - OP_W;
  localparam int TAP_W   = (FILTER_W > 1) ? $clog2(FILTER_W) : 1;
  localparam int POS_W   = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2,
    S_TRAIL = 2'd3
  } state_e;

  state_e                             state_q, state_d;
  logic [FILTER_W-1:0][WEIGHT_W-1:0]  w_q, w_d;
  logic [NUM_INPUTS-1:0]              spk_q, spk_d;
  logic [PSUM_W-1:0]                  acc_q, acc_d;
  logic [POS_W-1:0]                   pos_q, pos_d;
  logic [TAP_W-1:0]                   tap_q, tap_d;
  logic [ADDR_W-1:0]                  dest_q, dest_d;
  logic                               out_valid_q, out_valid_d;
  logic [PKT_W-1:0]                   out_data_q, out_data_d;
`ifdef PPE_ZERO_SKIP_EN
  logic [7:0]                         cnt_q, cnt_d;
`endif

  // ingress decode
  logic [OP_W-1:0] in_op;
  logic [PL_W-1:0] in_pl;
  logic [7:0]      in_idx;
  logic            accept;
  logic            hshk;
  logic            unused_dest;

  assign in_op       = io.in_data[PL_W +: OP_W];
  assign in_pl       = io.in_data[PL_W-1:0];
  assign in_idx      = in_pl[23:16];
  assign accept      = io.in_valid && (state_q == S_IDLE);
  assign hshk        = out_valid_q && io.out_ready;
  assign unused_dest = ^io.in_data[PKT_W-1 -: ADDR_W];

  // current tap operands, selected by compare loops so no index needs to be
  // wider or narrower than its array
  logic [WEIGHT_W-1:0] tap_w;
  logic                spk_bit;
  logic [POS_W-1:0]    sidx;
  logic [PSUM_W-1:0]   sum;
  logic                last_tap, last_pos;

  assign sidx     = pos_q + POS_W'(tap_q);
  assign last_tap = (tap_q == TAP_W'(FILTER_W - 1));
  assign last_pos = (pos_q == POS_W'(NUM_OUT - 1));

  always_comb begin
    tap_w   = '0;
    spk_bit = 1'b0;
    for (int k = 0; k < FILTER_W; k++)
      if (tap_q == TAP_W'(k)) tap_w = w_q[k];
    for (int j = 0; j < NUM_INPUTS; j++)
      if (sidx == POS_W'(j)) spk_bit = spk_q[j];
  end

  assign sum = acc_q + (spk_bit ? PSUM_W'(tap_w) : '0);

  function automatic logic [PKT_W-1:0] mk_pkt(input logic [ADDR_W-1:0] dst,
                                              input logic [OP_W-1:0] op,
                                              input logic [7:0] mid,
                                              input logic [15:0] lo);
    return PKT_W'({dst, op, mid, lo});
  endfunction

  // state register and all datapath flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      spk_q       <= '0;
      acc_q       <= '0;
      pos_q       <= '0;
      tap_q       <= '0;
      dest_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef PPE_ZERO_SKIP_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      spk_q       <= spk_d;
      acc_q       <= acc_d;
      pos_q       <= pos_d;
      tap_q       <= tap_d;
      dest_q      <= dest_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef PPE_ZERO_SKIP_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept && in_op == OP_W'(3)) state_d = S_ACCUM;
      S_ACCUM:
        if (last_tap) begin
          state_d = S_EMIT;
`ifdef PPE_ZERO_SKIP_EN
          if (sum == '0) state_d = last_pos ? S_TRAIL : S_ACCUM;
`endif
        end
      S_EMIT:
        if (hshk) begin
`ifdef PPE_ZERO_SKIP_EN
          state_d = last_pos ? S_TRAIL : S_ACCUM;
`else
          state_d = last_pos ? S_IDLE : S_ACCUM;
`endif
        end
      S_TRAIL:
        if (hshk) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // datapath next values
  always_comb begin
    w_d         = w_q;
    spk_d       = spk_q;
    acc_d       = acc_q;
    pos_d       = pos_q;
    tap_d       = tap_q;
    dest_d      = dest_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef PPE_ZERO_SKIP_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      S_IDLE:
        if (accept) begin
          if (in_op == OP_W'(1)) begin
            for (int k = 0; k < FILTER_W; k++)
              if (in_idx == 8'(k)) w_d[k] = in_pl[WEIGHT_W-1:0];
          end else if (in_op == OP_W'(2)) begin
            // chunks past the row never match any spike index
            for (int j = 0; j < NUM_INPUTS; j++)
              if (in_idx == 8'(j / 16)) spk_d[j] = in_pl[j % 16];
          end else if (in_op == OP_W'(3)) begin
            dest_d = in_pl[ADDR_W-1:0];
            pos_d  = '0;
            tap_d  = '0;
            acc_d  = '0;
`ifdef PPE_ZERO_SKIP_EN
            cnt_d  = '0;
`endif
          end else if (in_op == OP_W'(4)) begin
            w_d   = '0;
            spk_d = '0;
          end
        end
      S_ACCUM: begin
        acc_d = sum;
        tap_d = tap_q + 1'b1;
        if (last_tap) begin
          tap_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = mk_pkt(dest_q, OP_W'(8), pos_q, 16'(sum));
`ifdef PPE_ZERO_SKIP_EN
          if (sum == '0) begin
            if (last_pos) begin
              out_data_d = mk_pkt(dest_q, OP_W'(9), 8'h0, {8'h0, cnt_q});
            end else begin
              out_valid_d = 1'b0;
              out_data_d  = out_data_q;
              pos_d       = pos_q + 1'b1;
              acc_d       = '0;
            end
          end
`endif
        end
      end
      S_EMIT:
        if (hshk) begin
          out_valid_d = 1'b0;
`ifdef PPE_ZERO_SKIP_EN
          cnt_d = cnt_q + 1'b1;
          if (last_pos) begin
            // trailer follows the last psum back to back
            out_valid_d = 1'b1;
            out_data_d  = mk_pkt(dest_q, OP_W'(9), 8'h0, {8'h0, cnt_q + 8'd1});
          end
`endif
          if (!last_pos) begin
            pos_d = pos_q + 1'b1;
            tap_d = '0;
            acc_d = '0;
          end
        end
      S_TRAIL:
        if (hshk) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  // outputs
  always_comb begin
    io.in_ready  = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    io.out_valid = out_valid_q;
    io.out_data  = out_data_q;
  end
endmodule

// File: tb/tb_ppe_stream_engine.sv
module tb_ppe_stream_engine;
  localparam int FILTER_W   = 5;
  localparam int NUM_INPUTS = 25;
  localparam int WEIGHT_W   = 8;
  localparam int PSUM_W     = 11;
  localparam int ADDR_W     = 4;
  localparam int OP_W       = 4;
  localparam int PKT_W      = 32;
  localparam int NUM_OUT    = NUM_INPUTS - FILTER_W + 1;
  localparam int NCHUNK     = (NUM_INPUTS + 15) / 16;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  always #5 clk = ~clk;

  ppe_stream_engine_if #(.PKT_W(PKT_W)) io();

  ppe_stream_engine #(
    .FILTER_W(FILTER_W), .NUM_INPUTS(NUM_INPUTS), .WEIGHT_W(WEIGHT_W),
    .PSUM_W(PSUM_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .PKT_W(PKT_W)
  ) dut (
    .clk(clk), .reset(reset), .io(io), .busy(busy)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: stored rows and the packets the next row must produce
  int          w_m[FILTER_W];
  bit          s_m[NUM_INPUTS];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [23:0] pl);
    logic [3:0] junk_dst;
    junk_dst = 4'($urandom);
    return {junk_dst, op, pl};
  endfunction

  task automatic model_clear();
    foreach (w_m[k]) w_m[k] = 0;
    foreach (s_m[j]) s_m[j] = 1'b0;
  endtask

  task automatic build_exp(input logic [3:0] dest);
    int psum, sent;
    sent = 0;
    exp_q.delete();
    for (int p = 0; p < NUM_OUT; p++) begin
      psum = 0;
      for (int t = 0; t < FILTER_W; t++)
        if (s_m[p + t]) psum += w_m[t];
`ifdef PPE_ZERO_SKIP_EN
      if (psum != 0) begin
        exp_q.push_back({dest, 4'h8, 8'(p), 16'(psum)});
        sent++;
      end
`else
      exp_q.push_back({dest, 4'h8, 8'(p), 16'(psum)});
`endif
    end
`ifdef PPE_ZERO_SKIP_EN
    exp_q.push_back({dest, 4'h9, 16'h0, 8'(sent)});
`endif
  endtask

  task automatic model_apply(input logic [31:0] p);
    int idx;
    idx = int'(p[23:16]);
    case (p[27:24])
      4'h1: if (idx < FILTER_W) w_m[idx] = int'(p[WEIGHT_W-1:0]);
      4'h2: for (int i = 0; i < 16; i++)
              if (idx * 16 + i < NUM_INPUTS) s_m[idx * 16 + i] = p[i];
      4'h3: build_exp(p[3:0]);
      4'h4: model_clear();
      default: ;
    endcase
  endtask

  task automatic send(input logic [31:0] p, output int waits);
    waits = 0;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in_data  = p;
    while (!io.in_ready && waits < 2000) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    model_apply(p);
  endtask

  task automatic send_n(input logic [31:0] p);
    int w;
    send(p, w);
  endtask

  task automatic load_ramp_ones();
    for (int k = 0; k < FILTER_W; k++) send_n(mk(4'h1, {8'(k), 16'(k + 1)}));
    for (int c = 0; c < NCHUNK; c++) send_n(mk(4'h2, {8'(c), 16'hFFFF}));
  endtask

  // Drains the egress side until the row finishes (stop_after==0) or
  // stop_after packets have been observed.
  task automatic run_row(input bit bp, input int stop_after, input bit lat_chk);
    int cyc, got, lowc, rise1, rise2;
    bit prev_v, holding;
    logic [31:0] hold;
    cyc = 0; got = 0; lowc = 0; rise1 = -1; rise2 = -1;
    prev_v = 1'b0; holding = 1'b0; hold = '0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc > 5000) begin
        chk("row_timeout", 32'(busy), 32'd0);
        break;
      end
      io.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (holding) begin
        chk("hold_vld", 32'(io.out_valid), 32'd1);
        chk("hold_data", io.out_data, hold);
      end
      if (io.out_valid && !prev_v) begin
        if (rise1 < 0) rise1 = cyc;
        else if (rise2 < 0) rise2 = cyc;
      end
      if (!io.out_valid && rise1 < 0) lowc++;
      prev_v = io.out_valid;
      hold = io.out_data;
      if (io.out_valid && io.out_ready) begin
        chk("q_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("pkt", io.out_data, exp_q.pop_front());
        got++;
        holding = 1'b0;
        if (got == stop_after) break;
      end else begin
        holding = io.out_valid;
      end
      if (exp_q.size() == 0 && !busy && !io.out_valid) break;
    end
    if (lat_chk) begin
      chk("first_lat", 32'(lowc), 32'(FILTER_W));
      chk("period", 32'(rise2 - rise1), 32'(FILTER_W + 1));
    end
    if (stop_after == 0) chk("row_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w;
    logic [31:0] stall_pkt;
    reset = 1'b1;
    io.in_valid = 1'b0;
    io.in_data = '0;
    io.out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_out_data", io.out_data, 32'd0);
    reset = 1'b0;

    // ramp weights over all-ones spikes: psum 15 everywhere
    load_ramp_ones();
    send_n(mk(4'h3, 24'hA));
    run_row(1'b0, 0, 1'b1);

    // max weights: 1275 must fit in PSUM_W bits without wrap
    for (int k = 0; k < FILTER_W; k++) send_n(mk(4'h1, {8'(k), 16'hFF}));
    send_n(mk(4'h3, 24'h1));
    run_row(1'b1, 0, 1'b0);

    // single spike at position 0
    send_n(mk(4'h4, 24'h0));
    for (int k = 0; k < FILTER_W; k++) send_n(mk(4'h1, {8'(k), 16'(k + 1)}));
    send_n(mk(4'h2, {8'd0, 16'h0001}));
    send_n(mk(4'h3, 24'h3));
    run_row(1'b0, 0, 1'b0);

    // egress backpressure with an IFMAP packet waiting at ingress
    for (int c = 0; c < NCHUNK; c++) send_n(mk(4'h2, {8'(c), 16'hFFFF}));
    io.out_ready = 1'b0;
    send_n(mk(4'h3, 24'h5));
    w = 0;
    @(negedge clk);
    while (!io.out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("stall_first_vld", 32'(io.out_valid), 32'd1);
    stall_pkt = mk(4'h2, {8'd0, 16'h0000});
    io.in_valid = 1'b1;
    io.in_data = stall_pkt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_vld", 32'(io.out_valid), 32'd1);
      chk("stall_data", io.out_data, exp_q[0]);
      chk("stall_in_ready", 32'(io.in_ready), 32'd0);
    end
    run_row(1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    model_apply(stall_pkt);
    send_n(mk(4'h3, 24'h6));
    run_row(1'b0, 0, 1'b0);

    // reset in the middle of position 7
    for (int c = 0; c < NCHUNK; c++) send_n(mk(4'h2, {8'(c), 16'hFFFF}));
    send_n(mk(4'h3, 24'h7));
    run_row(1'b0, 7, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_vld", 32'(io.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("mid_rst_data", io.out_data, 32'd0);
    model_clear();
    exp_q.delete();
    send_n(mk(4'h3, 24'h8));
    run_row(1'b0, 0, 1'b0);

    // ignored packets: each takes one cycle and changes nothing
    load_ramp_ones();
    send(mk(4'h1, {8'd9, 16'h0077}), w);
    chk("ign_w_wait", 32'(w), 32'd0);
    chk("ign_w_busy", 32'(busy), 32'd0);
    send(mk(4'h2, {8'd5, 16'h0000}), w);
    chk("ign_c_wait", 32'(w), 32'd0);
    chk("ign_c_busy", 32'(busy), 32'd0);
    send(mk(4'hF, 24'($urandom)), w);
    chk("ign_op_wait", 32'(w), 32'd0);
    chk("ign_op_busy", 32'(busy), 32'd0);
    send_n(mk(4'h3, 24'h9));
    run_row(1'b0, 0, 1'b0);

    // randomized rows
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 2) == 0) send_n(mk(4'h4, 24'h0));
      for (int k = 0; k < FILTER_W + 1; k++)
        send_n(mk(4'h1, {8'($urandom_range(0, FILTER_W + 2)), 16'($urandom)}));
      for (int c = 0; c < NCHUNK; c++) begin
        // sparse spikes so zero psums show up too
        send_n(mk(4'h2, {8'(c), 16'($urandom & $urandom & $urandom)}));
      end
      if ($urandom_range(0, 1) == 0) send_n(mk(4'($urandom_range(5, 15)), 24'($urandom)));
      send_n(mk(4'h3, 24'($urandom_range(0, 15))));
      run_row(1'b1, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
